float_copro_issue: RTL and testbench

//  Issue stage directly upstream of the float coprocessor. Buffers CPU float requests
//  (opcode + 2 operands) in a small FIFO and drives the coprocessor's 4-phase handshake:

---
 rtl/float_copro_issue_pkg.sv | 31 +++
 rtl/float_req_fifo.sv | 43 ++++
 rtl/float_copro_issue.sv | 141 ++++++++++++++
 tb/tb_float_copro_issue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_copro_issue_pkg.sv
// Shared types for the float coprocessor issue stage: opcodes, request word, FSM states.
package float_copro_issue_pkg;

  typedef enum logic [10:0] {
    FOP_ADD = 11'd0,
    FOP_SUB = 11'd1,
    FOP_DIV = 11'd2,
    FOP_MUL = 11'd3
  } fop_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [10:0] opcode;
    logic [31:0] op0;
    logic [31:0] op1;
  } float_req_t;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_WRITE
  } issue_state_e;

  function automatic logic is_copro_op(input logic [10:0] op);
    return op inside {FOP_ADD, FOP_SUB, FOP_DIV, FOP_MUL};
  endfunction

endpackage

// File: rtl/float_req_fifo.sv
// Synchronous FIFO of float requests; head is visible the cycle after the push edge.
// Pointers carry one wrap bit so full/empty come straight from registered state.
module float_req_fifo
  import float_copro_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  float_req_t push_data,
  input  logic       pop,
  output float_req_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  float_req_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/float_copro_issue.sv
// Issue stage ahead of the float coprocessor: queues CPU requests, runs the 4-phase
// copro handshake with timeout, and returns in-order results on a valid/ready port.
module float_copro_issue
  import float_copro_issue_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [10:0] cpu_opcode,
  input  logic [31:0] cpu_op0,
  input  logic [31:0] cpu_op1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_error,
  output logic        copro_valid,
  output logic [10:0] copro_opcode,
  output logic [31:0] copro_op0,
  output logic [31:0] copro_op1,
  input  logic        copro_complete,
  input  logic [31:0] copro_result,
  output logic        busy
);

  localparam logic [15:0] TIMEOUT_CYC = TIMEOUT[15:0];

  issue_state_e state, state_nx;
  float_req_t   head, creq, creq_nx;
  logic         full, empty, pop, res_load;
  logic         cv_nx, stage_err, stage_err_nx;
  logic [31:0]  stage_data, stage_data_nx;
  logic [15:0]  timer, timer_nx, timer_inc;

  assign cpu_ready    = !full;
  assign copro_opcode = creq.opcode;
  assign copro_op0    = creq.op0;
  assign copro_op1    = creq.op1;
  assign busy         = !empty || (state != S_IDLE) || res_valid;
  assign timer_inc    = (timer == 16'hFFFF) ? timer : timer + 16'd1;

  float_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cpu_valid && cpu_ready),
    .push_data ({cpu_opcode, cpu_op0, cpu_op1}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_SYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    cv_nx         = copro_valid;
    creq_nx       = creq;
    timer_nx      = timer;
    stage_data_nx = stage_data;
    stage_err_nx  = stage_err;
    pop           = 1'b0;
    res_load      = 1'b0;
    case (state)
      // The coprocessor has no reset and may still be holding complete from before ours.
      S_SYNC: if (!copro_complete) state_nx = S_IDLE;
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_copro_op(head.opcode)) begin
            creq_nx  = head;
            cv_nx    = 1'b1;
            timer_nx = '0;
            state_nx = S_REQ;
          end else begin
            stage_data_nx = QNAN;
            stage_err_nx  = 1'b1;
            state_nx      = S_WRITE;
          end
        end
      end
      S_REQ: begin
        if (copro_complete) begin
          stage_data_nx = copro_result;
          stage_err_nx  = 1'b0;
          cv_nx         = 1'b0;
          state_nx      = S_RELEASE;
        end else begin
          timer_nx = timer_inc;
          if (timer_inc == TIMEOUT_CYC) begin
            cv_nx         = 1'b0;
            stage_data_nx = QNAN;
            stage_err_nx  = 1'b1;
            state_nx      = S_RELEASE;
          end
        end
      end
      S_RELEASE: if (!copro_complete) state_nx = S_WRITE;
      S_WRITE: begin
        if (!res_valid || res_ready) begin
          res_load = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      copro_valid <= 1'b0;
      creq        <= '0;
      timer       <= '0;
      stage_data  <= '0;
      stage_err   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_error   <= 1'b0;
    end else begin
      copro_valid <= cv_nx;
      creq        <= creq_nx;
      timer       <= timer_nx;
      stage_data  <= stage_data_nx;
      stage_err   <= stage_err_nx;
      if (res_load) begin
        res_valid <= 1'b1;
        res_data  <= stage_data;
        res_error <= stage_err;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_float_copro_issue.sv
// Directed bench for float_copro_issue with a 4-phase coprocessor model (DEPTH=4, TIMEOUT=8).
module tb_float_copro_issue;

  localparam logic [31:0] QNAN_W = 32'h7FC0_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_valid = 1'b0, res_ready = 1'b1;
  logic [10:0] cpu_opcode = '0;
  logic [31:0] cpu_op0 = '0, cpu_op1 = '0;
  logic        cpu_ready, res_valid, res_error, copro_valid, busy;
  logic [31:0] res_data, copro_op0, copro_op1, copro_result;
  logic [10:0] copro_opcode;
  logic        copro_complete = 1'b0;
  logic        copro_stall = 1'b0, copro_stuck = 1'b0;

  int errors = 0;
  int checks = 0;

  float_copro_issue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_opcode(cpu_opcode),
    .cpu_op0(cpu_op0), .cpu_op1(cpu_op1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .copro_valid(copro_valid), .copro_opcode(copro_opcode),
    .copro_op0(copro_op0), .copro_op1(copro_op1),
    .copro_complete(copro_complete), .copro_result(copro_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Coprocessor: raises complete the cycle after it sees valid, drops it once valid drops.
  assign copro_result = copro_op0 + copro_op1 + {21'd0, copro_opcode};
  always @(posedge clk) begin
    if (copro_stuck)                       copro_complete <= 1'b1;
    else if (copro_valid && !copro_stall)  copro_complete <= 1'b1;
    else if (!copro_valid)                 copro_complete <= 1'b0;
  end

  function automatic logic [31:0] model(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
    return a + b + {21'd0, op};
  endfunction

  task automatic push(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
    cpu_valid = 1'b1; cpu_opcode = op; cpu_op0 = a; cpu_op1 = b;
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({cpu_ready, res_valid, res_error, copro_valid, busy} !== 5'b10001) begin errors++;
      $display("FAIL reset_flags: got %b expected 10001", {cpu_ready, res_valid, res_error, copro_valid, busy}); end
    checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
    checks++; if ({copro_opcode, copro_op0, copro_op1} !== 75'h0) begin errors++;
      $display("FAIL reset_copro_fields: got %h expected 0", {copro_opcode, copro_op0, copro_op1}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_add_latency();
    int cnt;
    logic seen;
    logic [74:0] cfields;
    cnt = 0; seen = 1'b0; cfields = '0;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b expected 1", cpu_ready); end
    push(11'd0, 32'h3F80_0000, 32'h4000_0000);
    while (!res_valid && cnt < 30) begin
      @(negedge clk); cnt++;
      if (copro_valid && !seen) begin seen = 1'b1; cfields = {copro_opcode, copro_op0, copro_op1}; end
    end
    checks++; if (cnt !== 6) begin errors++; $display("FAIL add_latency: got %0d edges expected 6", cnt); end
    checks++; if (cfields !== {11'd0, 32'h3F80_0000, 32'h4000_0000}) begin errors++;
      $display("FAIL add_copro_fields: got %h expected %h", cfields, {11'd0, 32'h3F80_0000, 32'h4000_0000}); end
    checks++; if (res_data !== 32'h7F80_0000) begin errors++; $display("FAIL add_data: got %h expected 7f800000", res_data); end
    checks++; if (res_error !== 1'b0) begin errors++; $display("FAIL add_error: got %b expected 0", res_error); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", res_valid); end
  endtask

  task automatic test_bad_opcode();
    int cnt;
    logic saw_cv;
    cnt = 0; saw_cv = 1'b0;
    push(11'h7, 32'h1234_5678, 32'h9ABC_DEF0);
    while (!res_valid && cnt < 30) begin
      @(negedge clk); cnt++;
      if (copro_valid) saw_cv = 1'b1;
    end
    checks++; if (saw_cv !== 1'b0) begin errors++; $display("FAIL bad_op_copro_valid: got %b expected 0", saw_cv); end
    checks++; if (cnt !== 2) begin errors++; $display("FAIL bad_op_latency: got %0d expected 2", cnt); end
    checks++; if (res_data !== QNAN_W) begin errors++; $display("FAIL bad_op_data: got %h expected %h", res_data, QNAN_W); end
    checks++; if (res_error !== 1'b1) begin errors++; $display("FAIL bad_op_error: got %b expected 1", res_error); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [5], b [5], ed [5];
    logic        ee [5];
    int got, cyc, extra;
    for (int i = 0; i < 5; i++) begin
      a[i] = 32'h1000_0000 * i + 32'h11;
      b[i] = 32'h0000_0100 * i + 32'h5;
      ed[i] = (i < 4) ? model(11'(i), a[i], b[i]) : QNAN_W;
      ee[i] = (i == 4);
    end
    copro_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, cpu_ready); end
      push(11'(i), a[i], b[i]);
    end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b expected 0", cpu_ready); end
    cpu_valid = 1'b1; cpu_opcode = 11'd0; cpu_op0 = 32'hDEAD_0000; cpu_op1 = 32'h0000_BEEF;
    @(negedge clk);
    cpu_valid = 1'b0;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full: got %b expected 0", cpu_ready); end
    copro_stall = 1'b0;
    got = 0; cyc = 0;
    while (got < 5 && cyc < 200) begin
      if (res_valid && res_ready) begin
        checks++; if ({res_data, res_error} !== {ed[got], ee[got]}) begin errors++;
          $display("FAIL b2b_result_%0d: got %h/%b expected %h/%b", got, res_data, res_error, ed[got], ee[got]); end
        got++;
      end
      @(negedge clk); cyc++;
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", got); end
    extra = 0;
    repeat (20) begin @(negedge clk); if (res_valid) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_result: got %0d expected 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int cv_cnt, cyc, bad, got;
    logic [31:0] ed [2];
    logic        ee [2];
    ed[0] = QNAN_W; ee[0] = 1'b1;
    ed[1] = model(11'd1, 32'h4040_0000, 32'h0000_0777); ee[1] = 1'b0;
    copro_stall = 1'b1;
    push(11'd0, 32'h4120_0000, 32'h4130_0000);
    push(11'd1, 32'h4040_0000, 32'h0000_0777);
    cv_cnt = 0; cyc = 0;
    while (cyc < 60 && !(cv_cnt > 0 && !copro_valid)) begin
      if (copro_valid) begin
        cv_cnt++;
        if (cv_cnt == 8) copro_stuck = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    checks++; if (cv_cnt !== 8) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 8", cv_cnt); end
    bad = 0;
    repeat (6) begin @(negedge clk); if (copro_valid || res_valid) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_hold_release: got %0d active cycles expected 0", bad); end
    copro_stuck = 1'b0; copro_stall = 1'b0;
    got = 0; cyc = 0;
    while (got < 2 && cyc < 100) begin
      if (res_valid && res_ready) begin
        checks++; if ({res_data, res_error} !== {ed[got], ee[got]}) begin errors++;
          $display("FAIL timeout_result_%0d: got %h/%b expected %h/%b", got, res_data, res_error, ed[got], ee[got]); end
        got++;
      end
      @(negedge clk); cyc++;
    end
    checks++; if (got !== 2) begin errors++; $display("FAIL timeout_count: got %0d expected 2", got); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [3];
    logic [31:0] held;
    logic seen;
    int unstable, got, cyc;
    ed[0] = model(11'd2, 32'h0000_0010, 32'h0000_0020);
    ed[1] = model(11'd3, 32'h0000_0300, 32'h0000_0400);
    ed[2] = model(11'd1, 32'h0005_0000, 32'h0006_0000);
    res_ready = 1'b0;
    push(11'd2, 32'h0000_0010, 32'h0000_0020);
    push(11'd3, 32'h0000_0300, 32'h0000_0400);
    push(11'd1, 32'h0005_0000, 32'h0006_0000);
    seen = 1'b0; held = '0; unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) begin
        if (!seen) begin seen = 1'b1; held = res_data; end
        else if (res_data !== held) unstable++;
      end else if (seen) unstable++;
    end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b expected 1", res_valid); end
    checks++; if (held !== ed[0]) begin errors++; $display("FAIL bp_held_data: got %h expected %h", held, ed[0]); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
    res_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 3 && cyc < 100) begin
      if (res_valid && res_ready) begin
        checks++; if ({res_data, res_error} !== {ed[got], 1'b0}) begin errors++;
          $display("FAIL bp_result_%0d: got %h/%b expected %h/0", got, res_data, res_error, ed[got]); end
        got++;
      end
      @(negedge clk); cyc++;
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got); end
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    copro_stall = 1'b1;
    push(11'd0, 32'h0000_00AA, 32'h0000_00BB);
    push(11'd3, 32'h0000_00CC, 32'h0000_00DD);
    cyc = 0;
    while (!copro_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (copro_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_in_req: got %b expected 1", copro_valid); end
    copro_stuck = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (3) begin @(negedge clk); if (copro_valid) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_no_issue: got %0d expected 0", bad); end
    checks++; if ({cpu_ready, res_valid, res_error, copro_valid, busy} !== 5'b10001) begin errors++;
      $display("FAIL rst_mid_flags: got %b expected 10001", {cpu_ready, res_valid, res_error, copro_valid, busy}); end
    checks++; if ({res_data, copro_opcode, copro_op0, copro_op1} !== 107'h0) begin errors++;
      $display("FAIL rst_mid_regs: got %h/%h expected 0", res_data, {copro_opcode, copro_op0, copro_op1}); end
    copro_stuck = 1'b0; copro_stall = 1'b0;
    bad = 0;
    repeat (10) begin @(negedge clk); if (copro_valid || res_valid) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_fifo_flushed: got %0d expected 0", bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    push(11'd3, 32'h0000_1000, 32'h0000_2000);
    cyc = 0;
    while (!res_valid && cyc < 30) begin @(negedge clk); cyc++; end
    checks++; if ({res_valid, res_data, res_error} !== {1'b1, model(11'd3, 32'h0000_1000, 32'h0000_2000), 1'b0}) begin errors++;
      $display("FAIL rst_mid_recover: got %b/%h/%b expected 1/%h/0", res_valid, res_data, res_error,
               model(11'd3, 32'h0000_1000, 32'h0000_2000)); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_bad_opcode();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
